// File: rtl/vga_timing_pkg.sv
// Shared raster constants, default pixel type and a width helper
// for the VGA timing engine and its axis counters.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_R_W = 5;
    localparam int DEF_G_W = 6;
    localparam int DEF_B_W = 5;

    typedef struct packed {
        logic [DEF_R_W-1:0] r;
        logic [DEF_G_W-1:0] g;
        logic [DEF_B_W-1:0] b;
    } rgb_t;

    // Never returns less than 1 so degenerate sizes still give a legal vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// Host pixel handshake: the engine (master) requests a pixel by
// coordinate, the frame-buffer side (slave) answers with colour + valid.
interface vga_timing_engine_if
    import vga_timing_pkg::*;
#(
    parameter int R_W = DEF_R_W,
    parameter int G_W = DEF_G_W,
    parameter int B_W = DEF_B_W,
    parameter int X_W = clog2(DEF_H_ACTIVE),
    parameter int Y_W = clog2(DEF_V_ACTIVE)
);
    logic           oRequest;
    logic [X_W-1:0] oCoord_X;
    logic [Y_W-1:0] oCoord_Y;
    logic [R_W-1:0] iRed;
    logic [G_W-1:0] iGreen;
    logic [B_W-1:0] iBlue;
    logic           iValid;

    modport master (
        output oRequest, oCoord_X, oCoord_Y,
        input  iRed, iGreen, iBlue, iValid
    );

    modport slave (
        input  oRequest, oCoord_X, oCoord_Y,
        output iRed, iGreen, iBlue, iValid
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts sync, back porch, active, front porch
// and flags the sync/active regions of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_sync,
    output logic         in_active
);
    localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam int A_START = SYNC + BP;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = tick && (int'(count_q) == TOTAL - 1);
        count_d = count_q;
        if (clear || wrap) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count     = count_q;
    assign in_sync   = int'(count_q) < SYNC;
    assign in_active = (int'(count_q) >= A_START) &&
                       (int'(count_q) < A_START + ACTIVE);

endmodule

// File: rtl/vga_timing_engine.sv
// Raster timing engine: syncs, data-enable, lead-timed pixel requests
// and registered colour with underflow flag and frame counting.
module vga_timing_engine
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = DEF_R_W,
    parameter int G_W      = DEF_G_W,
    parameter int B_W      = DEF_B_W,
    parameter int REQ_LEAD = 2,
    parameter logic [R_W+G_W+B_W-1:0] UNDERFLOW_RGB = '0,
    parameter int FRAME_W  = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEnable,
    input  logic               iUnderflowClr,
    vga_timing_engine_if.master host,
    output logic [R_W-1:0]     oVGA_R,
    output logic [G_W-1:0]     oVGA_G,
    output logic [B_W-1:0]     oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_DE,
    output logic               oVGA_BLANK_N,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK,
    output logic               oFrameStart,
    output logic [FRAME_W-1:0] oFrameCnt,
    output logic               oUnderflow
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W      = clog2(H_TOTAL);
    localparam int VC_W      = clog2(V_TOTAL);
    localparam int X_W       = clog2(H_ACTIVE);
    localparam int Y_W       = clog2(V_ACTIVE);
    localparam int VA_START  = V_SYNC + V_BP;
    localparam int REQ_START = H_SYNC + H_BP - REQ_LEAD;
    localparam int REQ_END   = REQ_START + H_ACTIVE;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } pix_t;

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               de;
        logic               req;
        logic               fs;
        logic               uf;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        pix_t               rgb;
        logic [FRAME_W-1:0] fc;
    } out_t;

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            h_wrap, h_sync, h_act;
    logic            v_wrap, v_sync, v_act;
    logic            in_req;
    out_t            out_q;
    out_t            out_d;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HC_W)
    ) u_h (
        .clk(iCLK), .rst(iRST), .tick(iEnable), .clear(~iEnable),
        .count(hc), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VC_W)
    ) u_v (
        .clk(iCLK), .rst(iRST), .tick(h_wrap), .clear(~iEnable),
        .count(vc), .wrap(v_wrap), .in_sync(v_sync), .in_active(v_act)
    );

    // Request window is the active span shifted early by the lead.
    assign in_req = v_act &&
                    (int'(hc) >= REQ_START) && (int'(hc) < REQ_END);

    always_comb begin
        out_d     = out_q;
        out_d.hs  = ~HS_POL;
        out_d.vs  = ~VS_POL;
        out_d.de  = 1'b0;
        out_d.req = 1'b0;
        out_d.fs  = 1'b0;
        out_d.rgb = '0;
        if (!iEnable) begin
            out_d.x = '0;
            out_d.y = '0;
        end else begin
            out_d.hs  = h_sync ? HS_POL : ~HS_POL;
            out_d.vs  = v_sync ? VS_POL : ~VS_POL;
            out_d.de  = h_act && v_act;
            out_d.req = in_req;
            out_d.fs  = (hc == '0) && (vc == '0);
            if (in_req) begin
                out_d.x = X_W'(int'(hc) - REQ_START);
                out_d.y = Y_W'(int'(vc) - VA_START);
            end
            if (out_d.de) begin
                if (host.iValid) begin
                    out_d.rgb = '{r: host.iRed, g: host.iGreen, b: host.iBlue};
                end else begin
                    out_d.rgb = pix_t'(UNDERFLOW_RGB);
                end
            end
            out_d.uf = (out_d.de && !host.iValid) ||
                       (out_q.uf && !iUnderflowClr);
            if (h_wrap && v_wrap) out_d.fc = out_q.fc + FRAME_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            out_q    <= '0;
            out_q.hs <= ~HS_POL;
            out_q.vs <= ~VS_POL;
        end else begin
            out_q <= out_d;
        end
    end

    assign host.oRequest = out_q.req;
    assign host.oCoord_X = out_q.x;
    assign host.oCoord_Y = out_q.y;
    assign oVGA_R        = out_q.rgb.r;
    assign oVGA_G        = out_q.rgb.g;
    assign oVGA_B        = out_q.rgb.b;
    assign oVGA_H_SYNC   = out_q.hs;
    assign oVGA_V_SYNC   = out_q.vs;
    assign oVGA_DE       = out_q.de;
    assign oVGA_BLANK_N  = out_q.de;
    assign oVGA_SYNC     = 1'b0;
    assign oVGA_CLOCK    = iCLK;
    assign oFrameStart   = out_q.fs;
    assign oFrameCnt     = out_q.fc;
    assign oUnderflow    = out_q.uf;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a 16x8 raster: acts as the host,
// predicting every output from raster position arithmetic.
module tb_vga_timing_engine;

    localparam int R_W     = 5;
    localparam int G_W     = 6;
    localparam int B_W     = 5;
    localparam int X_W     = 3;
    localparam int Y_W     = 2;
    localparam int FRAME_W = 2;
    localparam int HT      = 16;
    localparam int FT      = 128;
    localparam logic [15:0] UF_RGB = 16'hF81F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;

    logic [R_W-1:0]     vga_r;
    logic [G_W-1:0]     vga_g;
    logic [B_W-1:0]     vga_b;
    logic               hs, vs, de, blank_n, vsync0, vclk, fs, uf;
    logic [FRAME_W-1:0] fcnt;

    always #5 clk = ~clk;

    vga_timing_engine_if #(
        .R_W(R_W), .G_W(G_W), .B_W(B_W), .X_W(X_W), .Y_W(Y_W)
    ) host ();

    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .R_W(R_W), .G_W(G_W), .B_W(B_W), .REQ_LEAD(2),
        .UNDERFLOW_RGB(UF_RGB), .FRAME_W(FRAME_W)
    ) dut (
        .iCLK(clk), .iRST(rst), .iEnable(en), .iUnderflowClr(clr),
        .host(host),
        .oVGA_R(vga_r), .oVGA_G(vga_g), .oVGA_B(vga_b),
        .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_DE(de),
        .oVGA_BLANK_N(blank_n), .oVGA_SYNC(vsync0), .oVGA_CLOCK(vclk),
        .oFrameStart(fs), .oFrameCnt(fcnt), .oUnderflow(uf)
    );

    typedef struct {
        bit          v;
        logic [15:0] rgb;
    } ent_t;

    int   n_chk = 0;
    int   n_bad = 0;
    int   pos   = 0;
    int   fc    = 0;
    bit   m_uf  = 0;
    int   ex    = 0;
    int   ey    = 0;
    bit   pend_v, pend_drop;
    int   pend_x, pend_y;
    int   drop_mode = 0;
    int   nreq;
    ent_t exp_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int          h, v;
        bit          va, ehs, evs, ede, ereq, efs, set;
        logic [15:0] ergb;
        logic [G_W-1:0] g;
        ent_t        e;
        ehs = 1; evs = 1; ede = 0; ereq = 0; efs = 0; set = 0;
        ergb = '0;
        @(posedge clk);
        #1;
        if (rst) begin
            pos = 0; fc = 0; m_uf = 0; ex = 0; ey = 0;
            exp_q.delete(); pend_v = 0;
        end else if (!en) begin
            pos = 0; ex = 0; ey = 0;
            exp_q.delete(); pend_v = 0;
        end else begin
            h    = pos % HT;
            v    = (pos / HT) % 8;
            ehs  = (h >= 3);
            evs  = (v >= 2);
            va   = (v >= 3) && (v < 7);
            ede  = va && (h >= 6) && (h < 14);
            ereq = va && (h >= 4) && (h < 12);
            if (ereq) begin
                ex = h - 4;
                ey = v - 3;
            end
            efs = (pos % FT) == 0;
            if (ede) begin
                chk("slot_queue", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e    = exp_q.pop_front();
                    ergb = e.v ? e.rgb : UF_RGB;
                    set  = !e.v;
                end
            end
            m_uf = set || (m_uf && !clr);
            if ((pos % FT) == FT - 1) fc = (fc + 1) % (1 << FRAME_W);
            pos++;
        end
        chk("hsync", hs, ehs);
        chk("vsync", vs, evs);
        chk("de", de, ede);
        chk("blank_n", blank_n, ede);
        chk("sync_tie", vsync0, 0);
        chk("request", host.oRequest, ereq);
        chk("coord_x", host.oCoord_X, ex);
        chk("coord_y", host.oCoord_Y, ey);
        chk("rgb", {vga_r, vga_g, vga_b}, ergb);
        chk("frame_start", fs, efs);
        chk("frame_cnt", fcnt, fc);
        chk("underflow", uf, m_uf);
        g = G_W'($urandom);
        if (pend_v) begin
            host.iValid = !pend_drop;
            host.iRed   = R_W'(pend_x);
            host.iGreen = g;
            host.iBlue  = B_W'(pend_y);
            e.v   = !pend_drop;
            e.rgb = {R_W'(pend_x), g, B_W'(pend_y)};
            exp_q.push_back(e);
        end else begin
            host.iValid = 1'($urandom);
            host.iRed   = R_W'($urandom);
            host.iGreen = g;
            host.iBlue  = B_W'($urandom);
        end
        pend_v = ereq;
        pend_x = ex;
        pend_y = ey;
        case (drop_mode)
            1:       pend_drop = (ex == 5) && (ey == 2);
            2:       pend_drop = ($urandom_range(0, 23) == 0);
            default: pend_drop = 0;
        endcase
    endtask

    initial begin
        host.iValid = 0;
        host.iRed   = '0;
        host.iGreen = '0;
        host.iBlue  = '0;
        pend_v = 0;
        pend_drop = 0;
        repeat (3) step();

        rst = 0;
        en  = 1;
        nreq = 0;
        repeat (FT) begin
            step();
            nreq += int'(host.oRequest);
        end
        chk("req_per_frame", nreq, 32);

        drop_mode = 1;
        repeat (FT) step();
        drop_mode = 0;
        chk("uf_sticky", uf, 1);
        clr = 1;
        step();
        clr = 0;
        step();

        for (int i = 0; i < 300 && (pos % FT) != 4 * HT + 9; i++) step();
        chk("reach_hc9_vc4", pos % FT, 4 * HT + 9);
        en = 0;
        repeat (3) step();
        en = 1;
        repeat (40) step();

        drop_mode = 2;
        for (int i = 0; i < 5 * FT + 20; i++) begin
            clr = ($urandom_range(0, 19) == 0);
            step();
        end

        for (int i = 0; i < 800; i++) begin
            if (en && $urandom_range(0, 149) == 0) en = 0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1;
            clr = ($urandom_range(0, 19) == 0);
            step();
        end

        en  = 1;
        clr = 0;
        repeat (20) step();
        for (int i = 0; i < 40 && (pos % HT) != 7; i++) step();
        chk("reach_midline", pos % HT, 7);
        rst = 1;
        step();
        rst = 0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
